// File: rtl/text_console_writer.sv
// Character-display feeder: turns CPU ASCII bytes into glyph codes and text-buffer
// writes, tracks the cursor and blanks rows and the whole screen.
module text_console_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [3:0] BLANK_CODE = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [3:0] new_char,
  output logic [11:0] waddr,
  output logic       text_en,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;

  state_t      state, state_nx;
  logic [11:0] clr_idx, clr_idx_nx;
  logic [11:0] row_base, row_base_nx;
  logic [6:0]  col_nx;
  logic [4:0]  row_nx;
  logic        text_en_nx;
  logic [3:0]  new_char_nx;
  logic [11:0] waddr_nx;

  logic        accept, printable, last_row, last_col;
  logic [4:0]  next_row;
  logic [11:0] next_base, cur_addr;

  function automatic logic [3:0] glyph(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39)      glyph = 4'(b - 8'h30);
    else if (b >= 8'h41 && b <= 8'h46) glyph = 4'(b - 8'h37);
    else if (b >= 8'h61 && b <= 8'h66) glyph = 4'(b - 8'h57);
    else                               glyph = BLANK_CODE;
  endfunction

  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = char_valid && char_ready;
  assign printable  = !(char_in < 8'h20 || char_in == 8'h7F);
  assign last_row   = (cursor_row == 5'(ROWS - 1));
  assign last_col   = (cursor_col == 7'(COLS - 1));
  assign next_row   = last_row ? 5'd0 : cursor_row + 5'd1;
  // row_base tracks row*COLS incrementally so no multiplier is needed
  assign next_base  = last_row ? 12'd0 : row_base + 12'(COLS);
  assign cur_addr   = row_base + {5'd0, cursor_col};

  always_comb begin
    state_nx    = state;
    clr_idx_nx  = clr_idx;
    row_base_nx = row_base;
    col_nx      = cursor_col;
    row_nx      = cursor_row;
    text_en_nx  = 1'b0;
    new_char_nx = new_char;
    waddr_nx    = waddr;
    case (state)
      IDLE: begin
        if (accept) begin
          case (char_in)
            8'h0A: begin
              col_nx      = 7'd0;
              row_nx      = next_row;
              row_base_nx = next_base;
              clr_idx_nx  = 12'd0;
              state_nx    = CLR_LINE;
            end
            8'h0D: col_nx = 7'd0;
            8'h08: begin
              if (cursor_col != 7'd0) begin
                col_nx      = cursor_col - 7'd1;
                text_en_nx  = 1'b1;
                new_char_nx = BLANK_CODE;
                waddr_nx    = cur_addr - 12'd1;
              end
            end
            8'h0C: begin
              col_nx      = 7'd0;
              row_nx      = 5'd0;
              row_base_nx = 12'd0;
              clr_idx_nx  = 12'd0;
              state_nx    = CLR_SCREEN;
            end
            default: begin
              if (printable) begin
                text_en_nx  = 1'b1;
                new_char_nx = glyph(char_in);
                waddr_nx    = cur_addr;
                if (last_col) begin
                  col_nx      = 7'd0;
                  row_nx      = next_row;
                  row_base_nx = next_base;
                  clr_idx_nx  = 12'd0;
                  state_nx    = CLR_LINE;
                end else begin
                  col_nx = cursor_col + 7'd1;
                end
              end
            end
          endcase
        end
      end
      // index runs one past the last cell so ready rises only after the final write
      CLR_LINE: begin
        if (clr_idx == 12'(COLS)) begin
          state_nx = IDLE;
        end else begin
          text_en_nx  = 1'b1;
          new_char_nx = BLANK_CODE;
          waddr_nx    = row_base + clr_idx;
          clr_idx_nx  = clr_idx + 12'd1;
        end
      end
      CLR_SCREEN: begin
        if (clr_idx == 12'(CELLS)) begin
          state_nx = IDLE;
        end else begin
          text_en_nx  = 1'b1;
          new_char_nx = BLANK_CODE;
          waddr_nx    = clr_idx;
          clr_idx_nx  = clr_idx + 12'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CLR_SCREEN;
      clr_idx    <= 12'd0;
      row_base   <= 12'd0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
      text_en    <= 1'b0;
      new_char   <= BLANK_CODE;
      waddr      <= 12'd0;
    end else begin
      state      <= state_nx;
      clr_idx    <= clr_idx_nx;
      row_base   <= row_base_nx;
      cursor_col <= col_nx;
      cursor_row <= row_nx;
      text_en    <= text_en_nx;
      new_char   <= new_char_nx;
      waddr      <= waddr_nx;
    end
  end

  // a stalled byte must be held steady by the source
  a_stable_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (char_valid && !char_ready) |=> (!char_valid || $stable(char_in)));

endmodule
